pp_accumulator: RTL and testbench
=================================

// Module: pp_accumulator
// PURPOSE
//  Downstream consumer of the 2-bit step counter in the 8x8 sequential multiplier.
//  Decodes count into nibble selects for the 4x4 multiplier, then shift-accumulates
//  its 8-bit partial products over 4 steps into a 16-bit product.
//  Provides a start/busy/done handshake.
//  Detects a broken count sequence, e.g. a counter clear mid-operation.
// PARAMETERS
//  PP_W   8   partial-product width (4x4 multiplier output)
//  NIB_W  4   nibble width; shift unit per step
//  OUT_W  16  product width; must equal 2*PP_W
// PORTS
//  clk       in   1      rising-edge clock, shared with the counter
//  aclr_n    in   1      asynchronous active-low reset
//  count_in  in   2      step from the counter (free-running 0,1,2,3,0,...)
//  start     in   1      request a multiply; sampled at posedge
//  pp_in     in   PP_W   4x4 multiplier result for the current a_sel/b_sel, same cycle
//  a_sel     out  1      A nibble select: 0=A[3:0], 1=A[7:4]
//  b_sel     out  1      B nibble select: 0=B[3:0], 1=B[7:4]
//  busy      out  1      high while state != IDLE
//  done      out  1      one-cycle pulse; product valid from this cycle on
//  product   out  OUT_W  last completed product; held until next completion
//  err       out  1      (START_ERR_EN only) sticky protocol error
// BEHAVIOUR
//  Clock, reset, and reset values
//   - One clock, clk; reset is asynchronous and active-low on aclr_n.
//   - Reset values: state=IDLE, acc=0, product=0, done=0, err=0, prev_step=0.
//  Step decode (combinational, always active, independent of state)
//   - a_sel=count_in[0]; b_sel=count_in[1].
//   - shift: 0 when count_in=0; NIB_W when count_in is 1 or 2; 2*NIB_W when count_in=3.
//   - term = {(OUT_W-PP_W)'b0, pp_in} << shift; the sum is OUT_W wide, no carry-out is possible.
//  FSM
//   - IDLE: start=1 -> ARM. done is held low except for its pulse.
//   - ARM: wait for count_in=0. In that cycle: acc<=term, prev_step<=0, go to RUN.
//   - RUN, count_in == prev_step+1:
//       - acc<=acc+term; prev_step<=count_in.
//       - If count_in=3: product<=acc+term, done<=1 for the next cycle only, go to IDLE.
//   - RUN, count_in != prev_step+1 (sequence break):
//       - Abort to IDLE. No done pulse; product is unchanged; acc is don't-care.
//  Latency and handshake
//   - start->done is 5..8 cycles, depending on count_in phase at start.
//     Minimum 5: start sampled while count_in=3.
//   - start is ignored when state != IDLE; requests are not queued.
//   - done and start in the same cycle: done still pulses; start is accepted, since state is IDLE.
//   - Operands A/B are held stable by the upstream mux owner while busy; not checked here.
//  Reset mid-operation
//   - aclr_n low -> immediate IDLE and reset values; any in-flight result is lost.
// CONFIGURATION
//  START_ERR_EN defined:
//   - err sets to 1 on start=1 while busy=1, or on a sequence-break abort.
//   - Cleared only by aclr_n.
//  START_ERR_EN undefined:
//   - err port and its logic are absent; such events are silently ignored or aborted.
// STRUCTURE
//  Package seq_mult_pkg:
//   - state enum {IDLE, ARM, RUN}
//   - localparams STEP_LL=0, STEP_HL=1, STEP_LH=2, STEP_HH=3
//   - function step_shift(step) returning 0 / NIB_W / 2*NIB_W
//  Sub-module step_decoder:
//   - count_in -> a_sel, b_sel, shift; purely combinational, reusable by the bench model.
//  Top level holds the FSM, acc, product, done, prev_step, and err registers.
// TESTING
//  1. A=0xAB, B=0xCD, pp_in from a 4x4 model, start while count_in=3.
//     -> done 5 cycles later; product=0x88EF.
//  2. A=0xFF, B=0xFF -> product=0xFE01.
//     Then A=0x00, B=0x5A -> product=0x0000 after the second done.
//  3. start pulsed twice during RUN.
//     -> single done; err=1 with START_ERR_EN, port absent without it.
//  4. Counter aclr mid-run, so count_in goes 1 -> 0.
//     -> abort, no done; product keeps the prior value; busy=0 next cycle.
//  5. aclr_n low during RUN.
//     -> product=0, busy=0, done=0 immediately; a new start after release completes correctly.
//  6. Sweep the start phase over count_in=0..3.
//     -> start->done latency is 8, 7, 6, 5 cycles respectively.

Source files
------------

// File: rtl/seq_mult_pkg.sv
//==============================================================================
// Package     : seq_mult_pkg
// Description : Shared types, step encodings and shift helper for the 8x8
//               sequential multiplier's partial-product path.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Step names read as {A nibble, B nibble}: L = low nibble, H = high nibble
    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_HL = 2'd1;
    localparam logic [1:0] STEP_LH = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    localparam int C_SHIFT_W = 8;

    function automatic logic [C_SHIFT_W-1:0] step_shift(
        input logic [1:0]           step,
        input logic [C_SHIFT_W-1:0] nib_w
    );
        case (step)
            STEP_LL:          return '0;
            STEP_HL, STEP_LH: return nib_w;
            default:          return nib_w << 1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/step_decoder.sv
//==============================================================================
// Module      : step_decoder
// Description : Combinational decode of the step counter into nibble selects
//               and the partial-product shift amount.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module step_decoder
    import seq_mult_pkg::*;
#(
    parameter int NIB_W = 4
) (
    input  logic [1:0]           i_count,
    output logic                 o_a_sel,
    output logic                 o_b_sel,
    output logic [C_SHIFT_W-1:0] o_shift
);

    assign o_a_sel = i_count[0];
    assign o_b_sel = i_count[1];
    assign o_shift = step_shift(i_count, C_SHIFT_W'(NIB_W));

endmodule

`default_nettype wire

// File: rtl/pp_accumulator.sv
//==============================================================================
// Module      : pp_accumulator
// Description : Shift-accumulates four 4x4 partial products into a 16-bit
//               product with start/busy/done handshake and sequence checking.
//               Optional sticky error flag enabled by macro START_ERR_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pp_accumulator
    import seq_mult_pkg::*;
#(
    parameter int PP_W  = 8,
    parameter int NIB_W = 4,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             aclr_n,
    input  logic [1:0]       count_in,
    input  logic             start,
    input  logic [PP_W-1:0]  pp_in,
    output logic             a_sel,
    output logic             b_sel,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] product
`ifdef START_ERR_EN
    ,
    output logic             err
`endif
);

    state_t                 r_state;
    logic [OUT_W-1:0]       r_acc;
    logic [OUT_W-1:0]       r_product;
    logic                   r_done;
    logic [1:0]             r_prev_step;

    logic [C_SHIFT_W-1:0]   w_shift;
    logic [OUT_W-1:0]       w_term;
    logic [OUT_W-1:0]       w_sum;
    logic [1:0]             w_next_step;
    logic                   w_in_seq;

    step_decoder #(
        .NIB_W   (NIB_W)
    ) u_step_decoder (
        .i_count (count_in),
        .o_a_sel (a_sel),
        .o_b_sel (b_sel),
        .o_shift (w_shift)
    );

    // Upper bits of the widened partial product are zero, so the sum never carries out
    assign w_term      = {{(OUT_W-PP_W){1'b0}}, pp_in} << w_shift;
    assign w_sum       = r_acc + w_term;
    assign w_next_step = r_prev_step + 2'd1;
    assign w_in_seq    = (count_in == w_next_step);

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_product   <= '0;
            r_done      <= 1'b0;
            r_prev_step <= STEP_LL;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARM;
                    end
                end
                ARM: begin
                    if (count_in == STEP_LL) begin
                        r_acc       <= w_term;
                        r_prev_step <= STEP_LL;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    if (w_in_seq) begin
                        r_acc       <= w_sum;
                        r_prev_step <= count_in;
                        if (count_in == STEP_HH) begin
                            r_product <= w_sum;
                            r_done    <= 1'b1;
                            r_state   <= IDLE;
                        end
                    end else begin
                        // Broken step sequence: drop the partial result silently
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef START_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            r_err <= 1'b0;
        end else if ((start && (r_state != IDLE)) || ((r_state == RUN) && !w_in_seq)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`endif

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_pp_accumulator.sv
//==============================================================================
// Module      : tb_pp_accumulator
// Description : Directed self-checking bench for pp_accumulator with a local
//               step counter and 4x4 multiplier model (START_ERR_EN aware).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pp_accumulator;

    logic        clk;
    logic        aclr_n;
    logic [1:0]  cnt;
    logic        cnt_clr;
    logic        start;
    logic [7:0]  pp_in;
    logic        a_sel;
    logic        b_sel;
    logic        busy;
    logic        done;
    logic [15:0] product;
`ifdef START_ERR_EN
    logic        err;
`endif

    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;

    int n_pass;
    int n_total;

    pp_accumulator #(
        .PP_W     (8),
        .NIB_W    (4),
        .OUT_W    (16)
    ) dut (
        .clk      (clk),
        .aclr_n   (aclr_n),
        .count_in (cnt),
        .start    (start),
        .pp_in    (pp_in),
        .a_sel    (a_sel),
        .b_sel    (b_sel),
        .busy     (busy),
        .done     (done),
        .product  (product)
`ifdef START_ERR_EN
        ,
        .err      (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_clr) cnt <= 2'd0;
        else         cnt <= cnt + 2'd1;
    end

    // 4x4 multiplier model fed by the nibble selects
    always_comb begin
        a_nib = a_sel ? op_a[7:4] : op_a[3:0];
        b_nib = b_sel ? op_b[7:4] : op_b[3:0];
        pp_in = {4'd0, a_nib} * {4'd0, b_nib};
    end

    task automatic wait_phase(input logic [1:0] ph);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cnt == ph) return;
        end
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] ph,
                          output int lat, output bit got);
        op_a = a;
        op_b = b;
        wait_phase(ph);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
    endtask

    task automatic test_reset();
        aclr_n  = 1'b0;
        cnt_clr = 1'b1;
        start   = 1'b0;
        op_a    = 8'h00;
        op_b    = 8'h00;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, done, product} !== 18'd0) $display("FAIL reset_outputs got=%h exp=0", {busy, done, product});
        else n_pass++;
`ifdef START_ERR_EN
        n_total++;
        if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err);
        else n_pass++;
`endif
        aclr_n  = 1'b1;
        cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_decode();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++;
            if ({b_sel, a_sel} !== cnt) $display("FAIL decode_sel got=%b exp=%b", {b_sel, a_sel}, cnt);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int lat;
        bit got;
        run_op(8'hAB, 8'hCD, 2'd3, lat, got);
        n_total++;
        if (!got || lat != 5) $display("FAIL basic_latency got=%0d exp=5 (done_seen=%0d)", lat, got);
        else n_pass++;
        n_total++;
        if (product !== 16'h88EF) $display("FAIL basic_product got=%h exp=88ef", product);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (done !== 1'b0 || product !== 16'h88EF) $display("FAIL basic_done_pulse got=%b/%h exp=0/88ef", done, product);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        run_op(8'hFF, 8'hFF, 2'd3, lat, got);
        n_total++;
        if (!got || product !== 16'hFE01) $display("FAIL b2b_first got=%h exp=fe01 (done_seen=%0d)", product, got);
        else n_pass++;
        op_a  = 8'h00;
        op_b  = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL b2b_start_on_done got=%b exp=1", busy);
        else n_pass++;
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        n_total++;
        if (!got || lat != 8) $display("FAIL b2b_latency got=%0d exp=8 (done_seen=%0d)", lat, got);
        else n_pass++;
        n_total++;
        if (product !== 16'h0000) $display("FAIL b2b_second got=%h exp=0000", product);
        else n_pass++;
    endtask

    task automatic test_start_during_run();
        int ndone;
        op_a = 8'h12;
        op_b = 8'h34;
        wait_phase(2'd3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) ndone++;
            if (i == 0 || i == 2) start = 1'b1;
            else                  start = 1'b0;
        end
        n_total++;
        if (ndone != 1) $display("FAIL run_start_done_count got=%0d exp=1", ndone);
        else n_pass++;
        n_total++;
        if (product !== 16'h03A8 || busy !== 1'b0) $display("FAIL run_start_product got=%h/%b exp=03a8/0", product, busy);
        else n_pass++;
`ifdef START_ERR_EN
        n_total++;
        if (err !== 1'b1) $display("FAIL run_start_err got=%b exp=1", err);
        else n_pass++;
`endif
    endtask

    task automatic test_seq_break();
        int ndone;
        op_a = 8'h77;
        op_b = 8'h99;
        wait_phase(2'd3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1 cnt_clr = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL break_busy_before got=%b exp=1", busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL break_busy_after got=%b exp=0", busy);
        else n_pass++;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_total++;
        if (ndone != 0 || product !== 16'h03A8) $display("FAIL break_no_done got=%0d/%h exp=0/03a8", ndone, product);
        else n_pass++;
`ifdef START_ERR_EN
        n_total++;
        if (err !== 1'b1) $display("FAIL break_err got=%b exp=1", err);
        else n_pass++;
`endif
    endtask

    task automatic test_async_reset();
        int lat;
        bit got;
        op_a = 8'h5A;
        op_b = 8'h3C;
        wait_phase(2'd3);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 aclr_n = 1'b0;
        #1;
        n_total++;
        if ({busy, done, product} !== 18'd0) $display("FAIL areset_outputs got=%h exp=0", {busy, done, product});
        else n_pass++;
`ifdef START_ERR_EN
        n_total++;
        if (err !== 1'b0) $display("FAIL areset_err got=%b exp=0", err);
        else n_pass++;
`endif
        @(negedge clk);
        aclr_n = 1'b1;
        run_op(8'h5A, 8'h3C, 2'd1, lat, got);
        n_total++;
        if (!got || lat != 7 || product !== 16'h1518)
            $display("FAIL areset_restart got=%0d/%h exp=7/1518 (done_seen=%0d)", lat, product, got);
        else n_pass++;
    endtask

    task automatic test_phase_sweep();
        logic [7:0]  ta [4];
        logic [7:0]  tb [4];
        logic [15:0] tp [4];
        int          tl [4];
        int          lat;
        bit          got;
        ta = '{8'h9C, 8'hE7, 8'h01, 8'h80};
        tb = '{8'h2E, 8'h03, 8'hF0, 8'h80};
        tp = '{16'h1C08, 16'h02B5, 16'h00F0, 16'h4000};
        tl = '{8, 7, 6, 5};
        for (int ph = 0; ph < 4; ph++) begin
            run_op(ta[ph], tb[ph], 2'(ph), lat, got);
            n_total++;
            if (!got || lat != tl[ph] || product !== tp[ph])
                $display("FAIL sweep_phase%0d got=%0d/%h exp=%0d/%h (done_seen=%0d)",
                         ph, lat, product, tl[ph], tp[ph], got);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_decode();
        test_basic();
        test_back_to_back();
        test_start_during_run();
        test_seq_break();
        test_async_reset();
        test_phase_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
